dmem_bank: RTL and testbench
============================

Name: dmem_bank

Overview:
- Parametrised single-port synchronous data memory; next generation of the core's data RAM.
- Adds configurable width/depth, per-byte write enables and a request/ready handshake.
- Adds a read-valid strobe, selectable read latency, out-of-range detection and a hardware zero-clear sweep after reset.
- Sits between the core's load/store unit and the address decoder that drives wr_select.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 10, word-index width; depth = 2**ADDR_W words.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = no clear.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request.
- we  in  1  write intent.
- wr_select  in  1  decoder select; a write happens only when we & wr_select.
- addr  in  32  word index; bits [ADDR_W-1:0] index the array.
- be  in  DATA_W/8  byte-lane write enables; be[i] covers wd[8i+7:8i].
- wd  in  DATA_W  write data.
- ready  out  1  block accepts a request this cycle.
- rd  out  DATA_W  read data; holds its last value between reads.
- rd_valid  out  1  one-cycle strobe: rd is new this cycle.
- err  out  1  one-cycle strobe: the access was out of range.

Behaviour:
- Reset (reset=0, asynchronous):
  - rd=0, rd_valid=0, err=0, ready=0.
  - Pipeline valids cleared; clear counter=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - Array contents are not touched asynchronously.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes 0 to word[clear counter], then counter+1.
  - After word 2**ADDR_W-1 is written, go to RUN on the next edge.
  - Duration is exactly 2**ADDR_W cycles after the first clock with reset=1.
  - ready=0 throughout; req is ignored.
- RUN:
  - ready=1 from the first edge in RUN.
  - An access is accepted when req & ready.
- Accepted write (we & wr_select):
  - Lanes with be[i]=1 are updated; other lanes keep their value.
  - No rd_valid strobe; rd unchanged.
  - be=0 is a legal no-op.
- Accepted read (otherwise, including we=1 with wr_select=0):
  - Array is read at the edge of acceptance.
  - READ_LAT=1: rd and rd_valid are updated at that same edge.
  - READ_LAT=2: result passes through one extra register; rd and rd_valid are updated one edge later.
  - Back-to-back reads are accepted every cycle; strobes come out in order, one per read.
- Out of range (addr[31:ADDR_W] != 0):
  - Access is still accepted.
  - A write is dropped; the array is unchanged.
  - A read returns rd=0 with rd_valid=1.
  - In both cases err=1 with the same latency as rd_valid would have.
- Read after write: a read of an address on the cycle after a write to it returns the new data. The array is single-port, so there is no same-cycle conflict.
- req=0: no array access; rd holds its value.
- Reset mid-CLEAR: sweep restarts from word 0.
- Reset mid-read (READ_LAT=2): in-flight read is discarded; no strobe after reset.
- Parameter checks: illegal READ_LAT, or DATA_W not a multiple of 8, is flagged at elaboration.

Test Plan:
- Reset release with defaults: ready=0 for exactly 1024 cycles, then 1. A read of address 5 then returns rd=0x00000000 with rd_valid=1 one cycle later.
- Full write, then partial write, then read:
  - Write addr=3, wd=0xDEADBEEF, be=4'hF.
  - Then write addr=3, wd=0x11223344, be=4'b0101.
  - Read addr=3 -> rd=0xDE22BE44.
- wr_select=0 with we=1, addr=3 -> no write; treated as a read. rd=0xDE22BE44 with rd_valid strobe; a later read of addr 3 still returns 0xDE22BE44.
- Out of range, write and read at addr=0x00000400:
  - Write -> err=1, word 0 unchanged.
  - Read -> rd=0, rd_valid=1, err=1.
- READ_LAT=2:
  - Reads of addr 1,2,3 (holding 0xA,0xB,0xC) on consecutive cycles.
  - rd_valid is high for 3 consecutive cycles starting 2 edges after the first accept.
  - rd sequence is 0xA,0xB,0xC.
- Reset mid-sweep: assert reset at sweep cycle 500; release. ready stays 0 for a full 1024 cycles, and a read of addr 1000 returns 0.

Source files
------------

// File: rtl/dmem_bank.sv
// Single-port synchronous data RAM with byte enables, req/ready handshake,
// selectable read latency, out-of-range flagging and a post-reset zero sweep.
module dmem_bank #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic                wr_select,
    input  logic [31:0]         addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wd,
    output logic                ready,
    output logic [DATA_W-1:0]   rd,
    output logic                rd_valid,
    output logic                err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    if (!(READ_LAT == 1 || READ_LAT == 2) || (DATA_W % 8) != 0) begin : g_bad_param
        $error("dmem_bank: READ_LAT must be 1 or 2 and DATA_W a multiple of 8");
    end

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   clear_cnt;
    logic                clr_we;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   idx;
    logic                in_range, accept, wr_any, wr_fire, rd_fire, oor_fire;
    logic [DATA_W-1:0]   s_data;

    assign idx      = addr[ADDR_W-1:0];
    assign in_range = (addr[31:ADDR_W] == '0);
    assign accept   = req & ready;
    assign wr_any   = accept & we & wr_select;
    assign wr_fire  = wr_any & in_range;
    assign rd_fire  = accept & ~(we & wr_select);
    assign oor_fire = accept & ~in_range;
    assign s_data   = in_range ? mem[idx] : '0;

    always_comb begin
        state_next = state;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (&clear_cnt) state_next = RUN;
            end
            RUN:     state_next = RUN;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clear_cnt <= '0;
            ready     <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == RUN);
            if (clr_we) clear_cnt <= clear_cnt + 1'b1;
        end
    end

    // NOTE: the array has no reset; contents are zeroed by the CLEAR sweep instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clear_cnt] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              p_valid, p_err;
        logic [DATA_W-1:0] p_data;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                p_valid  <= 1'b0;
                p_err    <= 1'b0;
                p_data   <= '0;
                rd       <= '0;
                rd_valid <= 1'b0;
                err      <= 1'b0;
            end else begin
                p_valid  <= rd_fire;
                p_err    <= oor_fire;
                if (rd_fire) p_data <= s_data;
                rd_valid <= p_valid;
                err      <= p_err;
                if (p_valid) rd <= p_data;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd       <= '0;
                rd_valid <= 1'b0;
                err      <= 1'b0;
            end else begin
                rd_valid <= rd_fire;
                err      <= oor_fire;
                if (rd_fire) rd <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bank.sv
// Self-checking bench for dmem_bank: two instances (READ_LAT 1 and 2) share
// stimulus and are compared every cycle against a word-array reference model.
module tb_dmem_bank;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, we = 1'b0, wr_select = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wd = '0;

    logic        ready1, rd_valid1, err1;
    logic        ready2, rd_valid2, err2;
    logic [31:0] rd1, rd2;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] model_mem [DEPTH];
    logic        model_ready;
    logic        exp_v1, exp_e1, exp_v2, exp_e2;
    logic [31:0] exp_rd1, exp_rd2;
    logic        pend_v, pend_e;
    logic [31:0] pend_d;

    always #5 clk = ~clk;

    dmem_bank #(.DATA_W(32), .ADDR_W(10), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .wr_select(wr_select),
        .addr(addr), .be(be), .wd(wd), .ready(ready1), .rd(rd1),
        .rd_valid(rd_valid1), .err(err1)
    );

    dmem_bank #(.DATA_W(32), .ADDR_W(10), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
        .clk(clk), .reset(reset), .req(req), .we(we), .wr_select(wr_select),
        .addr(addr), .be(be), .wd(wd), .ready(ready2), .rd(rd2),
        .rd_valid(rd_valid2), .err(err2)
    );

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // After a complete sweep every word is zero and all outputs are at reset values.
    task automatic model_after_sweep();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_v1 = 0; exp_e1 = 0; exp_v2 = 0; exp_e2 = 0;
        exp_rd1 = '0; exp_rd2 = '0;
        pend_v = 0; pend_e = 0; pend_d = '0;
        model_ready = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ready1 && ready2) && n < 3000);
        @(negedge clk);
    endtask

    // One clock of stimulus; model predicts both instances, then outputs are compared.
    task automatic step(input string tag, input logic r, input logic w, input logic s,
                        input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        logic        acc, oor, ev_v, ev_e;
        logic [31:0] ev_d;
        req = r; we = w; wr_select = s; addr = a; be = b; wd = d;
        acc  = r && model_ready;
        oor  = (a >= DEPTH);
        ev_v = acc && !(w && s);
        ev_e = acc && oor;
        ev_d = oor ? 32'h0 : model_mem[a % DEPTH];
        if (acc && w && s && !oor)
            for (int i = 0; i < 4; i++)
                if (b[i]) model_mem[a % DEPTH][8*i +: 8] = d[8*i +: 8];
        exp_v1 = ev_v; exp_e1 = ev_e;
        if (ev_v) exp_rd1 = ev_d;
        exp_v2 = pend_v; exp_e2 = pend_e;
        if (pend_v) exp_rd2 = pend_d;
        pend_v = ev_v; pend_e = ev_e; pend_d = ev_d;

        @(posedge clk); #1;
        checks++;
        if (ready1 !== model_ready || ready2 !== model_ready) begin
            errors++;
            $display("FAIL %s ready: got %b/%b expected %b", tag, ready1, ready2, model_ready);
        end
        checks++;
        if (rd_valid1 !== exp_v1 || err1 !== exp_e1) begin
            errors++;
            $display("FAIL %s lat1 strobes: got v=%b e=%b expected v=%b e=%b",
                     tag, rd_valid1, err1, exp_v1, exp_e1);
        end
        checks++;
        if (rd1 !== exp_rd1) begin
            errors++;
            $display("FAIL %s lat1 rd: got %h expected %h", tag, rd1, exp_rd1);
        end
        checks++;
        if (rd_valid2 !== exp_v2 || err2 !== exp_e2) begin
            errors++;
            $display("FAIL %s lat2 strobes: got v=%b e=%b expected v=%b e=%b",
                     tag, rd_valid2, err2, exp_v2, exp_e2);
        end
        checks++;
        if (rd2 !== exp_rd2) begin
            errors++;
            $display("FAIL %s lat2 rd: got %h expected %h", tag, rd2, exp_rd2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready1, rd_valid1, err1, rd1, ready2, rd_valid2, err2, rd2} !== '0) begin
            errors++;
            $display("FAIL reset_values: got r=%b v=%b e=%b rd=%h / r=%b v=%b e=%b rd=%h expected all 0",
                     ready1, rd_valid1, err1, rd1, ready2, rd_valid2, err2, rd2);
        end
        reset = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL sweep_length: got %0d cycles expected 1024", n);
        end
        model_after_sweep();
    endtask

    task automatic test_read_after_clear();
        step("clear_rd5", 1, 0, 0, 32'd5, 4'h0, 32'h0);
        checks++;
        if (rd1 !== 32'h0 || rd_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL clear_rd5_const: got rd=%h v=%b expected rd=00000000 v=1", rd1, rd_valid1);
        end
        step("clear_idle", 0, 0, 0, 32'd0, 4'h0, 32'h0);
    endtask

    task automatic test_partial_write();
        step("wr_full", 1, 1, 1, 32'd3, 4'hF, 32'hDEADBEEF);
        step("wr_part", 1, 1, 1, 32'd3, 4'b0101, 32'h11223344);
        step("wr_none", 1, 1, 1, 32'd3, 4'h0, 32'hFFFFFFFF);
        step("rd_part", 1, 0, 0, 32'd3, 4'h0, 32'h0);
        checks++;
        if (rd1 !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL partial_const: got %h expected de22be44", rd1);
        end
        step("part_idle", 0, 0, 0, 32'd0, 4'h0, 32'h0);
    endtask

    task automatic test_wr_select();
        step("nosel", 1, 1, 0, 32'd3, 4'hF, 32'h0BAD0BAD);
        checks++;
        if (rd1 !== 32'hDE22BE44 || rd_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL nosel_const: got rd=%h v=%b expected rd=de22be44 v=1", rd1, rd_valid1);
        end
        step("nosel_rd", 1, 0, 0, 32'd3, 4'h0, 32'h0);
        step("nosel_idle", 0, 0, 0, 32'd0, 4'h0, 32'h0);
    endtask

    task automatic test_out_of_range();
        step("w0", 1, 1, 1, 32'd0, 4'hF, 32'h5A5A5A5A);
        step("oor_wr", 1, 1, 1, 32'h400, 4'hF, 32'hFFFFFFFF);
        checks++;
        if (err1 !== 1'b1 || rd_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL oor_wr_const: got e=%b v=%b expected e=1 v=0", err1, rd_valid1);
        end
        step("oor_rd0", 1, 0, 0, 32'd0, 4'h0, 32'h0);
        step("oor_rd", 1, 0, 0, 32'h400, 4'h0, 32'h0);
        checks++;
        if (rd1 !== 32'h0 || rd_valid1 !== 1'b1 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL oor_rd_const: got rd=%h v=%b e=%b expected rd=0 v=1 e=1", rd1, rd_valid1, err1);
        end
        step("oor_high", 1, 0, 0, 32'h8000_0001, 4'h0, 32'h0);
        step("oor_idle", 0, 0, 0, 32'd0, 4'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        step("b2b_w1", 1, 1, 1, 32'd1, 4'hF, 32'hA);
        step("b2b_w2", 1, 1, 1, 32'd2, 4'hF, 32'hB);
        step("b2b_w3", 1, 1, 1, 32'd3, 4'hF, 32'hC);
        step("b2b_r1", 1, 0, 0, 32'd1, 4'h0, 32'h0);
        step("b2b_r2", 1, 0, 0, 32'd2, 4'h0, 32'h0);
        checks++;
        if (rd_valid2 !== 1'b1 || rd2 !== 32'hA) begin
            errors++;
            $display("FAIL b2b_lat2_first: got v=%b rd=%h expected v=1 rd=0000000a", rd_valid2, rd2);
        end
        step("b2b_r3", 1, 0, 0, 32'd3, 4'h0, 32'h0);
        step("b2b_idle1", 0, 0, 0, 32'd0, 4'h0, 32'h0);
        checks++;
        if (rd_valid2 !== 1'b1 || rd2 !== 32'hC) begin
            errors++;
            $display("FAIL b2b_lat2_last: got v=%b rd=%h expected v=1 rd=0000000c", rd_valid2, rd2);
        end
        step("b2b_idle2", 0, 0, 0, 32'd0, 4'h0, 32'h0);
    endtask

    task automatic test_random();
        logic r, w, s;
        logic [31:0] a, d;
        logic [3:0] b;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 7) != 0);
            w = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 15));
            b = 4'($urandom);
            d = $urandom;
            step("rand", r, w, s, a, b, d);
        end
        step("rand_idle", 0, 0, 0, 32'd0, 4'h0, 32'h0);
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        step("mid_w1000", 1, 1, 1, 32'd1000, 4'hF, 32'h12345678);
        step("mid_rd3", 1, 0, 0, 32'd3, 4'h0, 32'h0);
        reset = 1'b0;
        #1;
        checks++;
        if (rd_valid2 !== 1'b0 || rd2 !== 32'h0 || err2 !== 1'b0 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_reset: got v=%b rd=%h e=%b r=%b expected all 0",
                     rd_valid2, rd2, err2, ready1);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_no_strobe: got v=%b expected 0", rd_valid2);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (500) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_ready: got %b/%b expected 0", ready1, ready2);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL resweep_length: got %0d cycles expected 1024", n);
        end
        model_after_sweep();
        step("mid_rd1000", 1, 0, 0, 32'd1000, 4'h0, 32'h0);
        checks++;
        if (rd1 !== 32'h0 || rd_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd1000_const: got rd=%h v=%b expected rd=0 v=1", rd1, rd_valid1);
        end
        step("mid_idle", 0, 0, 0, 32'd0, 4'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_read_after_clear();
        test_partial_write();
        test_wr_select();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
